// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory access sequencer: size encodings,
// sequencer states and the lane helpers used to build memory requests.
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd1;
  localparam logic [1:0] SZ_HALF = 2'd2;
  // Any encoding other than SZ_BYTE/SZ_HALF is treated as a word.
  localparam logic [1:0] SZ_WORD = 2'd0;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } state_e;

  // Byte enables for an access; loads always fetch the whole word.
  function automatic logic [3:0] byte_en(input logic       is_write,
                                         input logic [1:0] size,
                                         input logic [1:0] addr_lo);
    logic [3:0] be;
    if (!is_write) begin
      be = 4'b1111;
    end else begin
      case (size)
        SZ_BYTE: be = 4'b0001 << addr_lo;
        SZ_HALF: be = addr_lo[1] ? 4'b1100 : 4'b0011;
        default: be = 4'b1111;
      endcase
    end
    return be;
  endfunction

  // Replicate the store datum across every lane it may land in.
  function automatic logic [31:0] store_data(input logic [1:0]  size,
                                             input logic [31:0] wdata);
    logic [31:0] d;
    case (size)
      SZ_BYTE: d = {4{wdata[7:0]}};
      SZ_HALF: d = {2{wdata[15:0]}};
      default: d = wdata;
    endcase
    return d;
  endfunction

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic m;
    case (size)
      SZ_BYTE: m = 1'b0;
      SZ_HALF: m = addr_lo[0];
      default: m = (addr_lo != 2'b00);
    endcase
    return m;
  endfunction

endpackage

// File: rtl/load_align.sv
// Extracts the addressed byte/half from a fetched word and sign- or
// zero-extends it; words pass through untouched.
module load_align
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  output logic [31:0] data
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Lane select and extension.
  always_comb begin
    byte_v = rdata[{addr_lo, 3'b000} +: 8];
    half_v = rdata[{addr_lo[1], 4'b0000} +: 16];
    case (size)
      SZ_BYTE: data = {{24{sign_ext & byte_v[7]}}, byte_v};
      SZ_HALF: data = {{16{sign_ext & half_v[15]}}, half_v};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Sequencer between the MEM stage and a multi-cycle data memory using a
// req/ack handshake. Holds the pipeline until the memory acknowledges, aborts
// accesses that exceed TIMEOUT_CYCLES wait cycles (0 disables the watchdog).
// Optional build macro MEM_MISALIGN_TRAP_EN: misaligned half/word requests
// are refused with a one-cycle AlignErr pulse instead of being aligned down.
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [1:0]  Size,
  input  logic        SignExt,
  input  logic [31:0] Addr,
  input  logic [31:0] WrData,
  output logic [31:0] LoadData,
  output logic        Stall,
  output logic        BusErr,
`ifdef MEM_MISALIGN_TRAP_EN
  output logic        AlignErr,
`endif
  output logic        DMemReq,
  output logic        DMemWe,
  output logic [31:0] DMemAddr,
  output logic [3:0]  DMemBe,
  output logic [31:0] DMemWData,
  input  logic [31:0] DMemRData,
  input  logic        DMemAck
);

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CntMax  = {CNT_W{1'b1}};

  state_e           state_q;
  logic [1:0]       size_q;
  logic [1:0]       addr_lo_q;
  logic             sext_q;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      aligned;
  logic             req;
  logic             trap;
  logic             timeout_hit;

  assign req = MemRead | MemWrite;

`ifdef MEM_MISALIGN_TRAP_EN
  assign trap = misaligned(Size, Addr[1:0]);
`else
  assign trap = 1'b0;
`endif

  // cnt_q counts BUSY cycles already spent without an ack.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CntLast);

  // Combinational so the pipeline is held in the request cycle itself.
  assign Stall = req && (state_q != StDone);

  load_align u_load_align (
    .rdata    (DMemRData),
    .addr_lo  (addr_lo_q),
    .size     (size_q),
    .sign_ext (sext_q),
    .data     (aligned)
  );

  // Sequencer FSM with registered memory-side outputs and status pulses.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q   <= StIdle;
      size_q    <= SZ_WORD;
      addr_lo_q <= 2'b00;
      sext_q    <= 1'b0;
      cnt_q     <= '0;
      DMemReq   <= 1'b0;
      DMemWe    <= 1'b0;
      DMemAddr  <= 32'h0;
      DMemBe    <= 4'b0000;
      DMemWData <= 32'h0;
      LoadData  <= 32'h0;
      BusErr    <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      AlignErr  <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req) begin
            if (trap) begin
`ifdef MEM_MISALIGN_TRAP_EN
              AlignErr <= 1'b1;
`endif
              state_q <= StDone;
            end else begin
              // A simultaneous read+write is performed as a write.
              DMemReq   <= 1'b1;
              DMemWe    <= MemWrite;
              DMemAddr  <= {Addr[31:2], 2'b00};
              DMemBe    <= byte_en(MemWrite, Size, Addr[1:0]);
              DMemWData <= store_data(Size, WrData);
              size_q    <= Size;
              addr_lo_q <= Addr[1:0];
              sext_q    <= SignExt;
              cnt_q     <= '0;
              state_q   <= StBusy;
            end
          end
        end
        StBusy: begin
          if (DMemAck) begin
            DMemReq <= 1'b0;
            if (!DMemWe) begin
              LoadData <= aligned;
            end
            state_q <= StDone;
          end else if (timeout_hit) begin
            DMemReq  <= 1'b0;
            BusErr   <= 1'b1;
            LoadData <= 32'h0;
            state_q  <= StDone;
          end else if (cnt_q != CntMax) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StDone: begin
          BusErr <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
          AlignErr <= 1'b0;
`endif
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl. A transaction-level model predicts the
// per-cycle Stall/DMemReq/BusErr/LoadData behaviour and request fields; a
// monitor compares every cycle, and literal checks pin the model.
module tb_mem_access_ctrl;

  localparam int unsigned TIMEOUT = 4;

  logic        Clk;
  logic        Rst;
  logic        MemRead;
  logic        MemWrite;
  logic [1:0]  Size;
  logic        SignExt;
  logic [31:0] Addr;
  logic [31:0] WrData;
  logic [31:0] LoadData;
  logic        Stall;
  logic        BusErr;
  logic        DMemReq;
  logic        DMemWe;
  logic [31:0] DMemAddr;
  logic [3:0]  DMemBe;
  logic [31:0] DMemWData;
  logic [31:0] DMemRData;
  logic        DMemAck;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        AlignErr;
`endif

  mem_access_ctrl #(
    .TIMEOUT_CYCLES (TIMEOUT),
    .CNT_W          (8)
  ) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .Size      (Size),
    .SignExt   (SignExt),
    .Addr      (Addr),
    .WrData    (WrData),
    .LoadData  (LoadData),
    .Stall     (Stall),
    .BusErr    (BusErr),
`ifdef MEM_MISALIGN_TRAP_EN
    .AlignErr  (AlignErr),
`endif
    .DMemReq   (DMemReq),
    .DMemWe    (DMemWe),
    .DMemAddr  (DMemAddr),
    .DMemBe    (DMemBe),
    .DMemWData (DMemWData),
    .DMemRData (DMemRData),
    .DMemAck   (DMemAck)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  int n_vec = 0;
  int n_err = 0;

  // Model state
  logic        mon_en;
  logic        exp_stall, exp_req, exp_buserr, exp_align, exp_we;
  logic [31:0] exp_addr, exp_wdata, exp_load;
  logic [3:0]  exp_be;

  // Values observed by the monitor, for literal checks
  logic [31:0] cap_addr, cap_wdata;
  logic [3:0]  cap_be;
  logic        cap_we;
  int          run_len = 0;
  int          last_run = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] m_be(input logic wr, input logic [1:0] sz, input logic [31:0] a);
    if (!wr) return 4'hF;
    if (sz == 2'd1) return 4'(1 << int'(a[1:0]));
    if (sz == 2'd2) return a[1] ? 4'hC : 4'h3;
    return 4'hF;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] wd);
    if (sz == 2'd1) return (wd & 32'hFF) * 32'h0101_0101;
    if (sz == 2'd2) return (wd & 32'hFFFF) * 32'h0001_0001;
    return wd;
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] sz, input logic sx,
                                         input logic [31:0] a, input logic [31:0] rd);
    logic [31:0] v;
    if (sz == 2'd1) begin
      v = (rd >> (8 * int'(a[1:0]))) & 32'hFF;
      if (sx && v >= 32'h80) v = v - 32'h100;
    end else if (sz == 2'd2) begin
      v = (rd >> (16 * int'(a[1]))) & 32'hFFFF;
      if (sx && v >= 32'h8000) v = v - 32'h1_0000;
    end else begin
      v = rd;
    end
    return v;
  endfunction

  function automatic logic m_trap(input logic [1:0] sz, input logic [31:0] a);
`ifdef MEM_MISALIGN_TRAP_EN
    if (sz == 2'd1) return 1'b0;
    if (sz == 2'd2) return a[0];
    return a[1:0] != 2'b00;
`else
    return (sz == 2'd3) && (a == 32'h1) && 1'b0;
`endif
  endfunction

  // Per-cycle comparison against the model, sampled mid-cycle.
  always @(negedge Clk) begin
    if (mon_en) begin
      check("stall", {31'b0, Stall}, {31'b0, exp_stall});
      check("dmem_req", {31'b0, DMemReq}, {31'b0, exp_req});
      check("bus_err", {31'b0, BusErr}, {31'b0, exp_buserr});
      check("load_data", LoadData, exp_load);
`ifdef MEM_MISALIGN_TRAP_EN
      check("align_err", {31'b0, AlignErr}, {31'b0, exp_align});
`endif
      if (exp_req) begin
        check("dmem_addr", DMemAddr, exp_addr);
        check("dmem_be", {28'b0, DMemBe}, {28'b0, exp_be});
        check("dmem_we", {31'b0, DMemWe}, {31'b0, exp_we});
        if (exp_we) check("dmem_wdata", DMemWData, exp_wdata);
        cap_addr  = DMemAddr;
        cap_be    = DMemBe;
        cap_we    = DMemWe;
        cap_wdata = DMemWData;
      end
      if (Stall) begin
        run_len++;
      end else if (run_len > 0) begin
        last_run = run_len;
        run_len  = 0;
      end
    end
  end

  // ack_after: BUSY cycle (1-based) carrying the ack; 0 means never.
  task automatic access(input logic rd, input logic wr, input logic [1:0] sz, input logic sx,
                        input logic [31:0] ad, input logic [31:0] wd, input logic [31:0] rdat,
                        input int ack_after);
    logic trap;
    logic timed_out;
    trap      = m_trap(sz, ad);
    timed_out = 1'b0;
    @(posedge Clk); #1;
    MemRead  = rd;
    MemWrite = wr;
    Size     = sz;
    SignExt  = sx;
    Addr     = ad;
    WrData   = wd;
    DMemAck  = 1'b0;
    exp_stall  = 1'b1;
    exp_req    = 1'b0;
    exp_buserr = 1'b0;
    exp_align  = 1'b0;
    exp_addr   = ad & 32'hFFFF_FFFC;
    exp_be     = m_be(wr, sz, ad);
    exp_we     = wr;
    exp_wdata  = m_wdata(sz, wd);
    if (!trap) begin
      for (int k = 1; k <= int'(TIMEOUT); k++) begin
        @(posedge Clk); #1;
        exp_req = 1'b1;
        if (k == ack_after) begin
          DMemAck   = 1'b1;
          DMemRData = rdat;
          break;
        end
        DMemAck   = 1'b0;
        DMemRData = 32'h5A5A_5A5A ^ 32'(k);
        if (k == int'(TIMEOUT)) timed_out = 1'b1;
      end
    end
    @(posedge Clk); #1;
    DMemAck    = 1'b0;
    exp_req    = 1'b0;
    exp_stall  = 1'b0;
    exp_buserr = timed_out;
    exp_align  = trap;
    if (timed_out) exp_load = 32'h0;
    else if (!trap && rd && !wr) exp_load = m_load(sz, sx, ad, rdat);
  endtask

  task automatic idle(input logic ack);
    @(posedge Clk); #1;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    DMemAck    = ack;
    DMemRData  = 32'hFFFF_FFFF;
    exp_stall  = 1'b0;
    exp_req    = 1'b0;
    exp_buserr = 1'b0;
    exp_align  = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    Rst = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; Size = 2'd0; SignExt = 1'b0;
    Addr = 32'h0; WrData = 32'h0; DMemRData = 32'h0; DMemAck = 1'b0;
    mon_en = 1'b0; exp_stall = 1'b0; exp_req = 1'b0; exp_buserr = 1'b0; exp_align = 1'b0;
    exp_we = 1'b0; exp_addr = 32'h0; exp_wdata = 32'h0; exp_load = 32'h0; exp_be = 4'h0;
    #12;
    check("rst_req", {31'b0, DMemReq}, 32'h0);
    check("rst_we", {31'b0, DMemWe}, 32'h0);
    check("rst_addr", DMemAddr, 32'h0);
    check("rst_be", {28'b0, DMemBe}, 32'h0);
    check("rst_wdata", DMemWData, 32'h0);
    check("rst_load", LoadData, 32'h0);
    check("rst_buserr", {31'b0, BusErr}, 32'h0);
    check("rst_stall", {31'b0, Stall}, 32'h0);
    @(negedge Clk);
    Rst    = 1'b1;
    mon_en = 1'b1;

    // sw, ack on third BUSY cycle
    access(1'b0, 1'b1, 2'd0, 1'b0, 32'h100, 32'hDEAD_BEEF, 32'h0, 3);
    idle(1'b0);
    check("sw_be", {28'b0, cap_be}, 32'hF);
    check("sw_addr", cap_addr, 32'h100);
    check("sw_we", {31'b0, cap_we}, 32'h1);
    check("sw_stall_len", 32'(last_run), 32'd4);

    // sb to top lane
    access(1'b0, 1'b1, 2'd1, 1'b0, 32'h103, 32'h0000_00A5, 32'h0, 1);
    idle(1'b0);
    check("sb_be", {28'b0, cap_be}, 32'h8);
    check("sb_wdata", cap_wdata, 32'hA5A5_A5A5);
    check("min_stall_len", 32'(last_run), 32'd2);

    // lb / lbu back-to-back
    access(1'b1, 1'b0, 2'd1, 1'b1, 32'h102, 32'h0, 32'h1280_FF00, 1);
    check("lb_load", LoadData, 32'hFFFF_FF80);
    access(1'b1, 1'b0, 2'd1, 1'b0, 32'h102, 32'h0, 32'h1280_FF00, 1);
    check("lbu_load", LoadData, 32'h0000_0080);

    // lh upper half, sh upper half
    access(1'b1, 1'b0, 2'd2, 1'b1, 32'h2, 32'h0, 32'h8001_ABCD, 1);
    check("lh_load", LoadData, 32'hFFFF_8001);
    access(1'b0, 1'b1, 2'd2, 1'b0, 32'h102, 32'h0000_1234, 32'h0, 2);
    idle(1'b0);
    check("sh_be", {28'b0, cap_be}, 32'hC);
    check("sh_wdata", cap_wdata, 32'h1234_1234);

    // lw with delayed ack, then lhu
    access(1'b1, 1'b0, 2'd0, 1'b0, 32'h104, 32'h0, 32'hCAFE_F00D, 2);
    idle(1'b0);
    access(1'b1, 1'b0, 2'd2, 1'b0, 32'h0, 32'h0, 32'h8001_ABCD, 1);
    idle(1'b0);
    check("lhu_load", LoadData, 32'h0000_ABCD);

    // Read+write together is a store and leaves LoadData alone
    access(1'b1, 1'b1, 2'd0, 1'b0, 32'h108, 32'h0BAD_F00D, 32'h1111_1111, 1);
    idle(1'b0);
    check("rw_we", {31'b0, cap_we}, 32'h1);
    check("rw_load_kept", LoadData, 32'h0000_ABCD);

    // Ack with no access in flight is ignored
    idle(1'b1);
    idle(1'b0);

    // No ack: watchdog abort
    access(1'b1, 1'b0, 2'd0, 1'b0, 32'h10C, 32'h0, 32'h0, 0);
    check("to_buserr", {31'b0, BusErr}, 32'h1);
    check("to_load", LoadData, 32'h0);
    idle(1'b0);
    check("to_stall_len", 32'(last_run), 32'd5);

    // Misaligned requests
    access(1'b1, 1'b0, 2'd0, 1'b0, 32'h101, 32'h0, 32'h7654_3210, 1);
    idle(1'b0);
`ifdef MEM_MISALIGN_TRAP_EN
    check("mis_lw_stall_len", 32'(last_run), 32'd1);
    check("mis_lw_load_kept", LoadData, 32'h0);
`else
    check("mis_lw_stall_len", 32'(last_run), 32'd2);
    check("mis_lw_load", LoadData, 32'h7654_3210);
`endif
    access(1'b1, 1'b0, 2'd2, 1'b1, 32'h103, 32'h0, 32'hBEEF_1234, 1);
    idle(1'b0);
`ifndef MEM_MISALIGN_TRAP_EN
    check("mis_lh_load", LoadData, 32'hFFFF_BEEF);
`endif

    // Reset while BUSY
    @(posedge Clk); #1;
    MemRead = 1'b1; MemWrite = 1'b0; Size = 2'd0; Addr = 32'h200;
    exp_stall = 1'b1; exp_req = 1'b0; exp_addr = 32'h200; exp_be = 4'hF; exp_we = 1'b0;
    @(posedge Clk); #1;
    exp_req = 1'b1;
    @(negedge Clk); #2;
    mon_en = 1'b0;
    Rst    = 1'b0;
    #1;
    check("rst_busy_req", {31'b0, DMemReq}, 32'h0);
    check("rst_busy_be", {28'b0, DMemBe}, 32'h0);
    check("rst_busy_load", LoadData, 32'h0);
    MemRead = 1'b0;
    exp_req = 1'b0; exp_stall = 1'b0; exp_buserr = 1'b0; exp_align = 1'b0; exp_load = 32'h0;
    run_len = 0;
    @(negedge Clk);
    Rst    = 1'b1;
    mon_en = 1'b1;
    access(1'b1, 1'b0, 2'd0, 1'b0, 32'h204, 32'h0, 32'h1357_2468, 2);
    check("post_rst_lw", LoadData, 32'h1357_2468);
    idle(1'b0);
    idle(1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
